// File: rtl/mem_pkg.sv
// mem_pkg: opcodes, FSM state encoding, access sizes and size/lane helpers
package mem_pkg;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic {IDLE, WAIT} state_e;
  typedef enum logic [1:0] {BYTE, HALF, WORD} size_e;

  // Unknown opcodes that still request memory fall back to a word access
  function automatic size_e size_of(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return BYTE;
      OP_LH, OP_LHU, OP_SH: return HALF;
      OP_LW, OP_SW:         return WORD;
      default:              return WORD;
    endcase
  endfunction

  function automatic logic is_signed(input logic [5:0] op);
    return op == OP_LB || op == OP_LH;
  endfunction

  function automatic logic [3:0] be_of(input size_e s, input logic [1:0] off);
    return s == BYTE ? 4'b0001 << off : s == HALF ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
  endfunction
endpackage

// File: rtl/mem_lane.sv
// mem_lane: little-endian lane replication for stores, extraction/extension for loads
import mem_pkg::*;

module mem_lane (
  input  size_e       size_i,
  input  logic        signed_i,
  input  logic        load_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);
  logic [31:0] sh, ld, st;
  assign sh = data_i >> {off_i, 3'b000};
  assign ld = size_i == BYTE ? {{24{signed_i & sh[7]}}, sh[7:0]} :
              size_i == HALF ? {{16{signed_i & sh[15]}}, sh[15:0]} : data_i;
  assign st = size_i == BYTE ? {4{data_i[7:0]}} :
              size_i == HALF ? {2{data_i[15:0]}} : data_i;
  assign data_o = load_i ? ld : st;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with a two-state bus handshake, stall and timeout abort
import mem_pkg::*;

module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] Inst,
  input  logic [31:0] Alu_out,
  input  logic [31:0] Store_data,
  input  logic [1:0]  M,
  input  logic [1:0]  WB,
  input  logic [4:0]  Dest_reg,
  output logic [31:0] Inst_out,
  output logic [31:0] Mem_result,
  output logic [1:0]  WB_out,
  output logic [4:0]  Dest_out,
  output logic        Stall,
  output logic        Misalign,
  output logic        Bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d, sgn_q, sgn_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  off_q, off_d;
  size_e       size_q, size_d;

  logic        rd, wr, op, aligned, in_wait, done, tmo, idle_go;
  size_e       size;
  logic        sgn;
  logic [31:0] st_data, ld_data;

  assign rd      = M == 2'b10;
  assign wr      = M == 2'b01;
  assign op      = rd | wr;
  assign size    = size_of(Inst[31:26]);
  assign sgn     = is_signed(Inst[31:26]);
  assign aligned = size == BYTE ? 1'b1 : size == HALF ? ~Alu_out[0] : Alu_out[1:0] == 2'b00;
  assign in_wait = state_q == WAIT;
  assign done    = in_wait & mem_ack;
  // A late ack on the last allowed cycle wins over the timeout
  assign tmo     = in_wait & ~mem_ack & cnt_q == LAST;
  assign idle_go = ~in_wait & op & aligned;

  mem_lane u_st (
    .size_i(size), .signed_i(sgn), .load_i(1'b0), .off_i(Alu_out[1:0]),
    .data_i(Store_data), .data_o(st_data)
  );

  mem_lane u_ld (
    .size_i(size_q), .signed_i(sgn_q), .load_i(1'b1), .off_i(off_q),
    .data_i(mem_rdata), .data_o(ld_data)
  );

  assign Misalign   = ~in_wait & op & ~aligned;
  assign Bus_err    = tmo;
  assign Stall      = idle_go | (in_wait & ~mem_ack & ~tmo);
  assign WB_out     = (idle_go | Misalign | (in_wait & ~done)) ? 2'b00 : WB;
  assign Mem_result = (done & ~we_q) ? ld_data : Alu_out;
  assign Inst_out   = Inst;
  assign Dest_out   = Dest_reg;
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_be     = be_q;
  assign mem_wdata  = wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    if (idle_go) begin
      state_d = WAIT;
      cnt_d   = '0;
      req_d   = 1'b1;
      we_d    = wr;
      addr_d  = {Alu_out[31:2], 2'b00};
      be_d    = be_of(size, Alu_out[1:0]);
      wdata_d = st_data;
      off_d   = Alu_out[1:0];
      size_d  = size;
      sgn_d   = sgn;
    end else if (done | tmo) begin
      state_d = IDLE;
      cnt_d   = '0;
      req_d   = 1'b0;
      we_d    = 1'b0;
    end else if (in_wait) begin
      cnt_d   = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      size_q  <= WORD;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven directed checks plus stall, timeout and reset sequences
module tb_mem_stage;
  logic        clock = 1'b0, reset_n = 1'b0;
  logic [31:0] Inst = '0, Alu_out = '0, Store_data = '0, mem_rdata = '0;
  logic [1:0]  M = '0, WB = 2'b11;
  logic [4:0]  Dest_reg = 5'd7;
  logic        mem_ack = 1'b0;
  logic [31:0] Inst_out, Mem_result, mem_addr, mem_wdata;
  logic [1:0]  WB_out;
  logic [4:0]  Dest_out;
  logic        Stall, Misalign, Bus_err, mem_req, mem_we;
  logic [3:0]  mem_be;
  int passed = 0, total = 0;

  mem_stage #(.TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n), .Inst(Inst), .Alu_out(Alu_out),
    .Store_data(Store_data), .M(M), .WB(WB), .Dest_reg(Dest_reg),
    .Inst_out(Inst_out), .Mem_result(Mem_result), .WB_out(WB_out),
    .Dest_out(Dest_out), .Stall(Stall), .Misalign(Misalign), .Bus_err(Bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // kind: 0 = access acked on 2nd WAIT cycle, 1 = misaligned, 2 = no memory op
  typedef struct {
    logic [5:0] opc; logic [1:0] m; logic [31:0] alu, sd, rd; int kind;
    logic [31:0] addr; logic [3:0] be; logic [31:0] wd; logic we; logic [31:0] res;
  } vec_t;
  vec_t tv[13];

  task automatic go(input logic [5:0] opc, input logic [1:0] m, input logic [31:0] alu, input logic [31:0] sd);
    @(negedge clock);
    Inst = {opc, 26'h155}; M = m; Alu_out = alu; Store_data = sd;
    #1;
  endtask

  initial begin
    tv[0]  = '{6'h20, 2'b10, 32'h103, 32'h0, 32'h80112233, 0, 32'h100, 4'b1000, 32'h0, 1'b0, 32'hFFFFFF80};
    tv[1]  = '{6'h24, 2'b10, 32'h103, 32'h0, 32'h80112233, 0, 32'h100, 4'b1000, 32'h0, 1'b0, 32'h00000080};
    tv[2]  = '{6'h29, 2'b01, 32'h202, 32'h0000ABCD, 32'h0, 0, 32'h200, 4'b1100, 32'hABCDABCD, 1'b1, 32'h202};
    tv[3]  = '{6'h21, 2'b10, 32'h102, 32'h0, 32'h80112233, 0, 32'h100, 4'b1100, 32'h0, 1'b0, 32'hFFFF8011};
    tv[4]  = '{6'h25, 2'b10, 32'h100, 32'h0, 32'h80112233, 0, 32'h100, 4'b0011, 32'h0, 1'b0, 32'h00002233};
    tv[5]  = '{6'h28, 2'b01, 32'h301, 32'h12345678, 32'h0, 0, 32'h300, 4'b0010, 32'h78787878, 1'b1, 32'h301};
    tv[6]  = '{6'h23, 2'b10, 32'h101, 32'h0, 32'h0, 1, 32'h0, 4'b0, 32'h0, 1'b0, 32'h101};
    tv[7]  = '{6'h21, 2'b10, 32'h103, 32'h0, 32'h0, 1, 32'h0, 4'b0, 32'h0, 1'b0, 32'h103};
    tv[8]  = '{6'h2B, 2'b01, 32'h400, 32'hCAFEF00D, 32'h0, 0, 32'h400, 4'b1111, 32'hCAFEF00D, 1'b1, 32'h400};
    tv[9]  = '{6'h00, 2'b10, 32'h204, 32'h0, 32'h11223344, 0, 32'h204, 4'b1111, 32'h0, 1'b0, 32'h11223344};
    tv[10] = '{6'h00, 2'b10, 32'h206, 32'h0, 32'h0, 1, 32'h0, 4'b0, 32'h0, 1'b0, 32'h206};
    tv[11] = '{6'h23, 2'b11, 32'h777, 32'h0, 32'h0, 2, 32'h0, 4'b0, 32'h0, 1'b0, 32'h777};
    tv[12] = '{6'h20, 2'b10, 32'h101, 32'h0, 32'h80112233, 0, 32'h100, 4'b0010, 32'h0, 1'b0, 32'h00000022};

    repeat (2) @(negedge clock);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_be", 32'(mem_be), 32'h0);
    chk("rst_stall", 32'(Stall), 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      go(tv[i].opc, tv[i].m, tv[i].alu, tv[i].sd);
      mem_rdata = tv[i].rd;
      if (tv[i].kind == 1) begin
        chk($sformatf("v%0d_misalign", i), {Misalign, Stall, 28'h0, WB_out}, 32'h80000000);
      end else if (tv[i].kind == 2) begin
        chk($sformatf("v%0d_pass_ctl", i), {Misalign, Stall, 28'h0, WB_out}, 32'h00000003);
        chk($sformatf("v%0d_pass_res", i), Mem_result, tv[i].res);
        chk($sformatf("v%0d_pass_dst", i), {Inst_out[31:26], 21'h0, Dest_out}, {tv[i].opc, 21'h0, 5'd7});
      end else begin
        chk($sformatf("v%0d_idle", i), {Misalign, Stall, 28'h0, WB_out}, 32'h40000000);
        @(negedge clock); #1;
        chk($sformatf("v%0d_bus_addr", i), mem_addr, tv[i].addr);
        chk($sformatf("v%0d_bus_ctl", i), {mem_req, mem_we, 26'h0, mem_be}, {mem_req ? 1'b1 : 1'b0, tv[i].we, 26'h0, tv[i].be} | 32'h80000000);
        chk($sformatf("v%0d_bus_wdata", i), mem_wdata, tv[i].wd);
        chk($sformatf("v%0d_w1_stall", i), 32'(Stall), 32'h1);
        @(negedge clock); mem_ack = 1'b1; #1;
        chk($sformatf("v%0d_ack_ctl", i), {Stall, Bus_err, 28'h0, WB_out}, 32'h00000003);
        chk($sformatf("v%0d_result", i), Mem_result, tv[i].res);
      end
      @(negedge clock); mem_ack = 1'b0; M = 2'b00; #1;
      chk($sformatf("v%0d_req_low", i), 32'(mem_req), 32'h0);
    end

    go(6'h23, 2'b10, 32'h100, 32'h0);
    mem_rdata = 32'hDEADBEEF;
    chk("lw_stall_c1", {31'h0, Stall}, 32'h1);
    @(negedge clock); #1; chk("lw_stall_c2", {31'h0, Stall}, 32'h1);
    @(negedge clock); #1; chk("lw_stall_c3", {31'h0, Stall}, 32'h1);
    @(negedge clock); mem_ack = 1'b1; #1;
    chk("lw_ack_stall", {31'h0, Stall}, 32'h0);
    chk("lw_result", Mem_result, 32'hDEADBEEF);
    chk("lw_wb", {30'h0, WB_out}, 32'h3);
    chk("lw_be", {28'h0, mem_be}, 32'hF);
    @(negedge clock); mem_ack = 1'b0; M = 2'b00;

    go(6'h23, 2'b10, 32'h500, 32'h0);
    begin
      int bad = 0;
      for (int k = 1; k <= 15; k++) begin
        @(negedge clock); #1;
        if (Bus_err !== 1'b0 || Stall !== 1'b1 || mem_req !== 1'b1) bad++;
      end
      chk("tmo_wait_bad_cycles", bad, 0);
    end
    @(negedge clock); #1;
    chk("tmo_abort", {Bus_err, Stall, 28'h0, WB_out}, 32'h80000000);
    @(negedge clock); M = 2'b00; #1;
    chk("tmo_after", {31'h0, mem_req | Bus_err}, 32'h0);
    go(6'h23, 2'b10, 32'h504, 32'h0);
    mem_rdata = 32'h0BADF00D;
    @(negedge clock); mem_ack = 1'b1; #1;
    chk("tmo_retry", Mem_result, 32'h0BADF00D);
    @(negedge clock); mem_ack = 1'b0; M = 2'b00;

    go(6'h23, 2'b10, 32'h508, 32'h0);
    mem_rdata = 32'h600DCAFE;
    repeat (15) @(negedge clock);
    @(negedge clock); mem_ack = 1'b1; #1;
    chk("last_ack", {Bus_err, Stall, 28'h0, WB_out}, 32'h00000003);
    chk("last_ack_res", Mem_result, 32'h600DCAFE);
    @(negedge clock); mem_ack = 1'b0; M = 2'b00;

    go(6'h23, 2'b10, 32'h100, 32'h0);
    @(negedge clock);
    @(negedge clock); #1;
    chk("rst_w2_req", 32'(mem_req), 32'h1);
    reset_n = 1'b0; M = 2'b00; #1;
    chk("rst_drop", {mem_req, Bus_err, Stall, 29'h0}, 32'h0);
    chk("rst_addr2", mem_addr, 32'h0);
    @(negedge clock); reset_n = 1'b1; Alu_out = 32'h55; mem_ack = 1'b1; #1;
    chk("idle_ack_ign", {Stall, Bus_err, 28'h0, WB_out}, 32'h00000003);
    chk("idle_ack_res", Mem_result, 32'h55);
    @(negedge clock); #1;
    chk("idle_ack_req", 32'(mem_req), 32'h0);
    mem_ack = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 16, meaning WAIT cycles without mem_ack before abort (range 2..255).
REQ-002 The module SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset_n, input, 1, with asynchronous active-low reset.
REQ-004 The module SHALL have port Inst, input, 32, the instruction from EX/MEM, with opcode in Inst[31:26].
REQ-005 The module SHALL have port Alu_out, input, 32, the effective address or ALU result.
REQ-006 The module SHALL have port Store_data, input, 32, the rt value for stores.
REQ-007 The module SHALL have port M, input, 2, with [1]=MemRead and [0]=MemWrite; 2'b11 is illegal and treated as 00.
REQ-008 The module SHALL have port WB, input, 2, the writeback controls; and port Dest_reg, input, 5.
REQ-009 The module SHALL have outputs Inst_out (32), Mem_result (32), WB_out (2) and Dest_out (5), all consumed by MEM_WB.
REQ-010 The module SHALL have output Stall, 1, which holds the PC and the IF/ID, ID/EX and EX/MEM registers.
REQ-011 The module SHALL have output Misalign, 1, and output Bus_err, 1, both one-cycle exception flags.
REQ-012 The module SHALL have memory outputs mem_req (1), mem_we (1), mem_addr (32, word-aligned), mem_be (4) and mem_wdata (32), and memory inputs mem_rdata (32) and mem_ack (1).

Function
REQ-013 Size decoding SHALL be: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B; any other opcode with M!=0 SHALL be treated as a word access.
REQ-014 Alignment SHALL be: halfword requires Alu_out[0]=0; word requires Alu_out[1:0]=0; byte is always aligned.
REQ-015 The FSM SHALL have states IDLE and WAIT.
REQ-016 In IDLE with no memory op: Stall=0; Mem_result=Alu_out; WB_out, Dest_out and Inst_out pass through (zero latency).
REQ-017 In IDLE with an aligned op: Stall=1 and WB_out=0 (bubble into MEM_WB); on the clock edge, latch addr {Alu_out[31:2],2'b00}, we, be, lane-shifted wdata and size/sign; go to WAIT.
REQ-018 In IDLE with a misaligned op: no request; Misalign=1, Stall=0 and WB_out=0, all in the same cycle.
REQ-019 In WAIT: mem_req=1 and the registered bus fields are held stable; the cycle counter increments every cycle.
REQ-020 In WAIT without mem_ack: Stall=1 and WB_out=0.
REQ-021 In WAIT with mem_ack: Stall=0; WB_out=WB; Mem_result = extracted load data for reads or Alu_out for stores; next state IDLE; counter cleared.
REQ-022 Little-endian lane mapping SHALL apply: the byte lane is addr[1:0] and the half lane is addr[1]; mem_be is 0001<<addr[1:0], 0011<<{addr[1],0} or 1111.
REQ-023 Store data SHALL be replicated into the selected lanes.
REQ-024 Load extraction SHALL sign-extend for lb/lh and zero-extend for lbu/lhu.
REQ-025 If the counter reaches TIMEOUT-1 with no mem_ack, the access SHALL abort: Bus_err=1 for that cycle, Stall=0, WB_out=0, next state IDLE.
REQ-026 mem_ack in IDLE SHALL be ignored.
REQ-027 mem_ack arriving on the TIMEOUT cycle SHALL count as success: no Bus_err.
REQ-028 Inputs SHALL be held stable by upstream while Stall=1.

Reset
REQ-029 reset_n low SHALL force state IDLE, counter 0, mem_req 0, mem_we 0, mem_addr 0, mem_be 0 and mem_wdata 0, asynchronously.
REQ-030 Reset in WAIT SHALL abandon the access with no Bus_err; the memory must tolerate a dropped request.
REQ-031 After reset, the combinational outputs SHALL follow REQ-016 to REQ-018.

Structure
REQ-032 Opcode constants, the state encoding and the size enumeration (BYTE, HALF, WORD) SHALL live in a shared package, mem_pkg, reused by the decoder and the EX stage.
REQ-033 Lane alignment and extension SHALL be one combinational sub-module, mem_lane, instantiated for both the store path and the load path.

Verification
REQ-034 The bench SHALL cover: lw, Alu_out=0x100, ack on the 3rd WAIT cycle, rdata=0xDEADBEEF -> Stall high 3 cycles, then Mem_result=0xDEADBEEF, WB_out=WB, mem_be=1111.
REQ-035 The bench SHALL cover: lb at 0x103, rdata=0x80112233 -> Mem_result=0xFFFFFF80; lbu at the same address -> Mem_result=0x00000080.
REQ-036 The bench SHALL cover: sh at 0x202, Store_data=0x0000ABCD -> mem_addr=0x200, mem_be=1100, mem_wdata[31:16]=0xABCD, mem_we=1.
REQ-037 The bench SHALL cover: lw at 0x101 -> Misalign=1, mem_req stays 0, Stall=0, WB_out=0.
REQ-038 The bench SHALL cover: lw with mem_ack never asserted, TIMEOUT=16 -> Bus_err pulses on the 16th WAIT cycle, then IDLE; a second lw with ack completes normally.
REQ-039 The bench SHALL cover: reset_n low in the 2nd WAIT cycle -> mem_req falls immediately, state IDLE, no Bus_err; a later mem_ack is ignored.
